// File: rtl/int_csr_pkg.sv
// int_csr_pkg: shared constants and types for the interrupt CSR slave
package int_csr_pkg;
    // Register word indices, taken from byte address bits [3:2]
    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_SET     = 2'd2;
    localparam logic [1:0] REG_CLAIM   = 2'd3;
    localparam int CLAIM_ANY_BIT = 31;
    typedef enum logic {IDLE, RESP} state_t;
endpackage

// File: rtl/int_csr_prio_enc.sv
// prio_enc: index of the lowest set bit of vec_i plus an any-bit-set flag
// Ports:
//   vec_i  in  N   input vector
//   idx_o  out IW  lowest set index, 0 when vec_i is zero
//   any_o  out 1   vec_i is nonzero
module prio_enc #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    // Scanning from the top lets the lowest set bit win the last assignment
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--)
            if (vec_i[i]) idx_o = IW'(i);
    end
    assign any_o = |vec_i;
endmodule

// File: rtl/int_csr.sv
// int_csr: CPU register slave for the interrupt controller (pending, enable, set, claim)
// Ports:
//   clk_i, rst_i (async, active-high)
//   req_valid_i/req_ready_o/req_write_i/req_addr_i/req_wdata_i  bus request
//   rsp_valid_o/rsp_ready_i/rsp_rdata_o                          bus response
//   pending_i        pending vector from the controller
//   enabled_o        enable mask to the controller
//   clear_strobe_o   one-cycle W1C pulse
//   sw_set_strobe_o  one-cycle software-set pulse
module int_csr
    import int_csr_pkg::*;
#(
    parameter int NUM_INT = 8,
    parameter int IDX_W   = (NUM_INT > 1) ? $clog2(NUM_INT) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_write_i,
    input  logic [3:0]         req_addr_i,
    input  logic [31:0]        req_wdata_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [31:0]        rsp_rdata_o,
    input  logic [NUM_INT-1:0] pending_i,
    output logic [NUM_INT-1:0] enabled_o,
    output logic [NUM_INT-1:0] clear_strobe_o,
    output logic [NUM_INT-1:0] sw_set_strobe_o
);
    state_t             state;
    logic [NUM_INT-1:0] hit, wbits;
    logic [IDX_W-1:0]   idx;
    logic               any, accept;
    logic [1:0]         sel;
    logic [31:0]        rd_mux;
    logic               unused_bits;

    assign unused_bits = ^{req_addr_i[1:0], req_wdata_i};
    assign sel         = req_addr_i[3:2];
    assign wbits       = req_wdata_i[NUM_INT-1:0];
    assign hit         = pending_i & enabled_o;
    assign accept      = req_valid_i && state == IDLE;
    assign req_ready_o = state == IDLE;
    assign rsp_valid_o = state == RESP;

    prio_enc #(.N(NUM_INT), .IW(IDX_W)) u_prio (
        .vec_i (hit),
        .idx_o (idx),
        .any_o (any)
    );

    always_comb begin
        rd_mux = sel == REG_PENDING ? 32'(pending_i) :
                 sel == REG_ENABLE  ? 32'(enabled_o) :
                 sel == REG_CLAIM   ? 32'(idx)       : '0;
        if (sel == REG_CLAIM) rd_mux[CLAIM_ANY_BIT] = any;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            rsp_rdata_o     <= '0;
            enabled_o       <= '0;
            clear_strobe_o  <= '0;
            sw_set_strobe_o <= '0;
        end else begin
            // Strobes default low so each write yields a single-cycle pulse
            clear_strobe_o  <= '0;
            sw_set_strobe_o <= '0;
            if (accept) begin
                state           <= RESP;
                rsp_rdata_o     <= req_write_i ? '0 : rd_mux;
                clear_strobe_o  <= req_write_i && sel == REG_PENDING ? wbits : '0;
                sw_set_strobe_o <= req_write_i && sel == REG_SET ? wbits : '0;
                if (req_write_i && sel == REG_ENABLE) enabled_o <= wbits;
            end else if (state == RESP && rsp_ready_i) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_int_csr.sv
// tb_int_csr: randomized self-checking bench for int_csr against a register-level model
module tb_int_csr;
    localparam int N = 8;

    logic          clk = 0, rst_i = 1;
    logic          req_valid_i = 0, req_write_i = 0, rsp_ready_i = 0;
    logic [3:0]    req_addr_i = 0;
    logic [31:0]   req_wdata_i = 0;
    logic [N-1:0]  pending_i = 0;
    logic          req_ready_o, rsp_valid_o;
    logic [31:0]   rsp_rdata_o;
    logic [N-1:0]  enabled_o, clear_strobe_o, sw_set_strobe_o;

    int checks = 0, errors = 0;
    logic [N-1:0] m_en = 0;

    always #5 clk = ~clk;

    int_csr #(.NUM_INT(N)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .pending_i(pending_i), .enabled_o(enabled_o),
        .clear_strobe_o(clear_strobe_o), .sw_set_strobe_o(sw_set_strobe_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Register-map reference: what a read of register r returns for pending p
    function automatic logic [31:0] model_read(input logic [1:0] r, input logic [N-1:0] p);
        logic [N-1:0] h;
        h = p & m_en;
        case (r)
            2'd0: return 32'(p);
            2'd1: return 32'(m_en);
            2'd2: return 0;
            default: begin
                for (int i = 0; i < N; i++)
                    if (h[i]) return 32'h8000_0000 + i;
                return 0;
            end
        endcase
    endfunction

    // One full transaction, driven and sampled on negedges, with `stall` cycles of backpressure
    task automatic txn(input logic w, input logic [1:0] r, input logic [31:0] d,
                       input logic [N-1:0] p, input int stall);
        logic [31:0] exp_rd;
        logic [N-1:0] exp_clr, exp_set;
        exp_rd  = w ? 0 : model_read(r, p);
        exp_clr = (w && r == 2'd0) ? d[N-1:0] : '0;
        exp_set = (w && r == 2'd2) ? d[N-1:0] : '0;
        req_valid_i = 1; req_write_i = w; req_addr_i = {r, 2'($urandom)};
        req_wdata_i = d; pending_i = p;
        chk("req_ready_idle", 32'(req_ready_o), 1);
        @(posedge clk); @(negedge clk);
        req_valid_i = 0;
        if (w && r == 2'd1) m_en = d[N-1:0];
        chk("rsp_valid", 32'(rsp_valid_o), 1);
        chk("rdata", rsp_rdata_o, exp_rd);
        chk("clear_strobe", 32'(clear_strobe_o), 32'(exp_clr));
        chk("set_strobe", 32'(sw_set_strobe_o), 32'(exp_set));
        chk("enabled", 32'(enabled_o), 32'(m_en));
        chk("req_ready_busy", 32'(req_ready_o), 0);
        rsp_ready_i = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); @(negedge clk);
            chk("hold_valid", 32'(rsp_valid_o), 1);
            chk("hold_rdata", rsp_rdata_o, exp_rd);
            chk("hold_strobes", 32'({clear_strobe_o, sw_set_strobe_o}), 0);
            chk("hold_ready", 32'(req_ready_o), 0);
            rsp_ready_i = (i == stall - 1);
        end
        @(posedge clk); @(negedge clk);
        rsp_ready_i = 0;
        chk("done_valid", 32'(rsp_valid_o), 0);
        chk("done_ready", 32'(req_ready_o), 1);
        chk("done_strobes", 32'({clear_strobe_o, sw_set_strobe_o}), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(rsp_valid_o), 0);
        chk("rst_rdata", rsp_rdata_o, 0);
        chk("rst_enabled", 32'(enabled_o), 0);
        chk("rst_strobes", 32'({clear_strobe_o, sw_set_strobe_o}), 0);
        rst_i = 0;
        chk("rst_ready", 32'(req_ready_o), 1);

        // Directed test plan
        txn(0, 2'd1, 0, 0, 0);
        txn(1, 2'd1, 32'h0000_00A5, 0, 0);
        txn(0, 2'd1, 0, 0, 0);
        txn(1, 2'd1, 32'hFFFF_FFFF, 0, 0);
        txn(0, 2'd1, 0, 0, 0);
        txn(1, 2'd2, 32'h12, 0, 0);
        txn(1, 2'd1, 32'h10, 0, 0);
        txn(0, 2'd3, 0, 8'h12, 0);
        txn(1, 2'd1, 0, 0, 0);
        txn(0, 2'd3, 0, 8'h12, 0);
        txn(1, 2'd0, 32'h05, 8'h0F, 0);
        txn(1, 2'd0, 0, 8'h0F, 0);
        txn(1, 2'd2, 0, 8'h0F, 0);
        txn(1, 2'd3, 32'hFFFF_FFFF, 8'h0F, 0);
        txn(0, 2'd2, 0, 8'h0F, 0);
        txn(0, 2'd0, 0, 8'hC3, 5);

        // Second request held valid during backpressure is accepted only after release
        txn(1, 2'd1, 32'h0000_0081, 0, 0);
        req_valid_i = 1; req_write_i = 0; req_addr_i = 4'h4; pending_i = 8'h80;
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid_o), 1);
            chk("bp_ready", 32'(req_ready_o), 0);
            chk("bp_rdata", rsp_rdata_o, 32'h81);
            rsp_ready_i = (i == 4);
            @(posedge clk); @(negedge clk);
        end
        rsp_ready_i = 0;
        chk("bp_idle_valid", 32'(rsp_valid_o), 0);
        chk("bp_idle_ready", 32'(req_ready_o), 1);
        req_addr_i = 4'hC;
        @(posedge clk); @(negedge clk);
        req_valid_i = 0;
        chk("bp_second_valid", 32'(rsp_valid_o), 1);
        chk("bp_second_rdata", rsp_rdata_o, 32'h8000_0007);
        rsp_ready_i = 1;
        @(posedge clk); @(negedge clk);
        rsp_ready_i = 0;

        // Randomized traffic
        for (int k = 0; k < 300; k++)
            txn(1'($urandom), 2'($urandom), $urandom, N'($urandom), $urandom_range(0, 2));

        // Asynchronous reset in the middle of a strobe cycle
        txn(1, 2'd1, 32'h3, 0, 0);
        req_valid_i = 1; req_write_i = 1; req_addr_i = 4'h0; req_wdata_i = 32'h1;
        @(posedge clk); #1;
        req_valid_i = 0;
        chk("pre_rst_strobe", 32'(clear_strobe_o), 1);
        chk("pre_rst_enabled", 32'(enabled_o), 3);
        rst_i = 1; #1;
        chk("arst_valid", 32'(rsp_valid_o), 0);
        chk("arst_rdata", rsp_rdata_o, 0);
        chk("arst_enabled", 32'(enabled_o), 0);
        chk("arst_strobes", 32'({clear_strobe_o, sw_set_strobe_o}), 0);
        @(negedge clk);
        rst_i = 0; m_en = 0;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(req_ready_o), 1);
        @(negedge clk);
        txn(0, 2'd1, 0, 8'hFF, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_csr.md
Name: int_csr

Overview:
- CPU-facing register slave that sits directly downstream of the interrupt controller.
- Consumes the controller's pending vector and owns the per-source enable register, which feeds back to the controller.
- Turns software writes into one-cycle clear/set strobes for the controller.
- Provides a claim register holding the lowest-numbered pending and enabled source.

Parameters:
- NUM_INT, 8: number of interrupt sources; legal range 1..31.
- IDX_W, $clog2(NUM_INT) (min 1): width of the claim index field.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  bus request valid
- req_ready_o  out  1  bus request accepted when valid&ready
- req_write_i  in  1  1=write, 0=read
- req_addr_i  in  4  byte address; bits [3:2] select register, bits [1:0] ignored
- req_wdata_i  in  32  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  32  read data; 0 for writes
- pending_i  in  NUM_INT  pending vector from the interrupt controller
- enabled_o  out  NUM_INT  enable mask to the interrupt controller
- clear_strobe_o  out  NUM_INT  one-cycle W1C pulse to the controller
- sw_set_strobe_o  out  NUM_INT  one-cycle software-set pulse; top ORs it with hardware set strobes

Behaviour:
- Register map:
  - 0x0 PENDING: read = pending_i; write-1-to-clear.
  - 0x4 ENABLE: read/write; reset 0.
  - 0x8 SET: write-1-to-set; reads 0.
  - 0xC CLAIM: read-only. Bit 31 = any (pending & enabled) nonzero; bits [IDX_W-1:0] = lowest set index of (pending & enabled), or 0 if none. Writes ignored.
- Bits at or above NUM_INT read 0 and are ignored on write.
- FSM has two states:
  - IDLE: req_ready_o=1, rsp_valid_o=0.
  - RESP: req_ready_o=0, rsp_valid_o=1.
- Transitions:
  - IDLE -> RESP on req_valid_i (accept cycle).
  - RESP -> IDLE when rsp_ready_i=1.
  - RESP holds and rsp_rdata_o stays stable while rsp_ready_i=0.
- One outstanding transaction; peak throughput one request per 2 cycles.
- Read data is sampled from pending_i/enable in the accept cycle and registered. It appears with rsp_valid_o in the next cycle, so latency is 1.
- Writes:
  - ENABLE updates at the accept-cycle clock edge; enabled_o is visible the next cycle.
  - clear_strobe_o = wdata[NUM_INT-1:0] for exactly the one cycle after accept when writing PENDING, else 0.
  - sw_set_strobe_o behaves the same way for writes to SET.
  - Both strobes are registered and pulse in the same cycle rsp_valid_o first rises.
- Writing 0 to PENDING or SET: response still issued, strobe stays all-zero.
- Clear and set of the same bit cannot be simultaneous from this block, since there is one transaction at a time. The controller gives set priority if the top-level hardware set coincides with the clear.
- CLAIM does not modify state; software must W1C PENDING to acknowledge.
- Reset, including mid-transaction:
  - FSM returns to IDLE; in-flight response dropped.
  - rsp_valid_o=0, rsp_rdata_o=0, enabled_o=0, both strobes 0.
  - req_ready_o=1 in the first cycle after reset deassertion.

Decomposition:
- Package int_csr_pkg:
  - register offset constants REG_PENDING=0, REG_ENABLE=1, REG_SET=2, REG_CLAIM=3 (word indices);
  - CLAIM_ANY_BIT=31;
  - FSM state typedef enum {IDLE, RESP}.
- Sub-module prio_enc (parameter N): combinational lowest-set-bit index plus any flag, instantiated for CLAIM.
- Kept separate so it is unit-testable and reusable for the bus arbiter.

Test Plan:
- After reset, read ENABLE -> rsp_rdata_o=0, enabled_o=0, rsp_valid_o exactly 1 cycle after accept.
- Write ENABLE=0x0000_00A5, then read -> 0xA5; enabled_o=0xA5 from the cycle after accept. Write 0xFFFF_FFFF with NUM_INT=8 -> reads back 0xFF.
- Write SET=0x12 -> sw_set_strobe_o=0x12 for exactly one cycle. Then, with pending_i=0x12 and ENABLE=0x10, read CLAIM -> 0x8000_0004; with ENABLE=0, read CLAIM -> 0x0000_0000.
- With pending_i=0x0F, write PENDING=0x05 -> clear_strobe_o=0x05 for one cycle, 0 otherwise. Write PENDING=0 -> strobe stays 0 and a response is still issued.
- Hold rsp_ready_i=0 for 5 cycles after a read -> rsp_valid_o held with stable data, req_ready_o=0. A second req_valid_i is not accepted until the cycle after rsp_ready_i=1.
- Assert rst_i while in RESP, with ENABLE=0x3 and a pending strobe cycle -> all outputs 0 immediately (async). After release, req_ready_o=1 and ENABLE reads 0.
